// File: rtl/bundle_serializer.sv
// Serializes a LANES-wide masked bundle into one lane per beat, lowest lane first.
// Holds its own copy of the bundle so upstream only needs to present it in the accept cycle.
module bundle_serializer #(
  parameter type T     = logic,
  parameter int  LANES = 2,
  parameter int  IDXW  = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mispredict,
  input  logic             valid_in,
  output logic             ready_in,
  input  T                 data_in [LANES],
  input  logic [LANES-1:0] mask_in,
  output logic             valid_out,
  input  logic             ready_out,
  output T                 data_out,
  output logic [IDXW-1:0]  lane_out,
  output logic             last_out,
  output logic [LANES-1:0] pending_out
);

  // Handshakes: a transfer happens on a port exactly in a cycle where its valid and
  // ready are both high; valid never depends on ready on the same port.

  T                 buf_q [LANES];
  T                 buf_d [LANES];
  logic [LANES-1:0] pend_q, pend_d;
  logic [IDXW-1:0]  cur;
  logic             busy;
  logic             fire_out;
  logic             accept;

  always_comb begin
    cur = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (pend_q[i]) cur = IDXW'(i);
    end
  end

  assign busy        = (pend_q != '0);
  assign valid_out   = busy && !mispredict;
  assign fire_out    = valid_out && ready_out;
  assign last_out    = busy && ((pend_q & (pend_q - LANES'(1))) == '0);
  assign pending_out = pend_q;
  assign data_out    = busy ? buf_q[cur] : '0;
  assign lane_out    = busy ? cur : '0;

  // Accepting on the final beat keeps back-to-back bundles bubble-free.
  assign ready_in = !mispredict && reset && (!busy || (fire_out && last_out));
  assign accept   = valid_in && ready_in;

  always_comb begin
    pend_d = pend_q;
    buf_d  = buf_q;
    if (mispredict) begin
      pend_d = '0;
      for (int i = 0; i < LANES; i++) buf_d[i] = '0;
    end else begin
      if (fire_out) pend_d[cur] = 1'b0;
      if (accept) begin
        pend_d = mask_in;
        buf_d  = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      for (int i = 0; i < LANES; i++) buf_q[i] <= '0;
    end else begin
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

endmodule

// File: tb/tb_bundle_serializer.sv
// Bench for bundle_serializer: directed 2-lane and 4-lane sequences plus random
// 4-lane traffic checked against an in-order lane queue.
module tb_bundle_serializer;

  logic clk;
  logic reset;

  // 2-lane instance
  logic       a_mispredict, a_valid_in, a_ready_in, a_valid_out, a_ready_out, a_last_out;
  logic [7:0] a_data_in [2];
  logic [1:0] a_mask_in, a_pending_out;
  logic [7:0] a_data_out;
  logic [0:0] a_lane_out;

  // 4-lane instance
  logic       b_mispredict, b_valid_in, b_ready_in, b_valid_out, b_ready_out, b_last_out;
  logic [7:0] b_data_in [4];
  logic [3:0] b_mask_in, b_pending_out;
  logic [7:0] b_data_out;
  logic [1:0] b_lane_out;

  int checks = 0;
  int errors = 0;
  logic       sb_en = 1'b0;
  logic [9:0] exp_q[$];

  bundle_serializer #(.T(logic [7:0]), .LANES(2)) u_dut2 (
    .clk(clk), .reset(reset), .mispredict(a_mispredict),
    .valid_in(a_valid_in), .ready_in(a_ready_in), .data_in(a_data_in), .mask_in(a_mask_in),
    .valid_out(a_valid_out), .ready_out(a_ready_out), .data_out(a_data_out),
    .lane_out(a_lane_out), .last_out(a_last_out), .pending_out(a_pending_out)
  );

  bundle_serializer #(.T(logic [7:0]), .LANES(4)) u_dut4 (
    .clk(clk), .reset(reset), .mispredict(b_mispredict),
    .valid_in(b_valid_in), .ready_in(b_ready_in), .data_in(b_data_in), .mask_in(b_mask_in),
    .valid_out(b_valid_out), .ready_out(b_ready_out), .data_out(b_data_out),
    .lane_out(b_lane_out), .last_out(b_last_out), .pending_out(b_pending_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: drive just after the rising edge, sample on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [7:0] d1, input logic [7:0] d0,
                         input logic [1:0] m);
    step();
    a_valid_in   = v;
    a_data_in[1] = d1;
    a_data_in[0] = d0;
    a_mask_in    = m;
  endtask

  task automatic a_out(input string tag, input logic v, input logic [7:0] d,
                       input logic l, input logic last, input logic rdy);
    chk({tag, "_valid"}, a_valid_out, v);
    chk({tag, "_data"},  a_data_out, d);
    chk({tag, "_lane"},  a_lane_out, l);
    chk({tag, "_last"},  a_last_out, last);
    chk({tag, "_rdyin"}, a_ready_in, rdy);
  endtask

  // scoreboard on the 4-lane instance: pop on output beat, push on accept
  always @(negedge clk) begin
    if (sb_en && reset) begin
      if (b_valid_out && b_ready_out) begin
        logic [9:0] exp_v;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("sb_beat", {b_lane_out, b_data_out}, exp_v);
      end
      if (b_valid_in && b_ready_in && !b_mispredict) begin
        for (int i = 0; i < 4; i++)
          if (b_mask_in[i]) exp_q.push_back({2'(i), b_data_in[i]});
      end
    end
  end

  initial begin
    reset = 1'b0;
    a_mispredict = 0; a_valid_in = 0; a_ready_out = 0; a_mask_in = '0;
    a_data_in[0] = '0; a_data_in[1] = '0;
    b_mispredict = 0; b_valid_in = 0; b_ready_out = 0; b_mask_in = '0;
    for (int i = 0; i < 4; i++) b_data_in[i] = '0;

    // 1. reset then idle
    #3;
    a_out("rst", 0, 8'h00, 0, 0, 0);
    chk("rst_pend", a_pending_out, 2'b00);
    #9 reset = 1'b1;
    @(negedge clk);
    a_out("idle", 0, 8'h00, 0, 0, 1);

    // 2. full bundle, then back-to-back second bundle
    a_ready_out = 1;
    a_drive(1, 8'hB2, 8'hA1, 2'b11);
    @(negedge clk); chk("b2b_acc_rdy", a_ready_in, 1);
    a_drive(0, 8'h00, 8'h00, 2'b00);
    @(negedge clk); a_out("b2b_c1", 1, 8'hA1, 0, 0, 0);
    a_drive(1, 8'hD4, 8'hC3, 2'b11);
    @(negedge clk); a_out("b2b_c2", 1, 8'hB2, 1, 1, 1);
    a_drive(0, 8'h00, 8'h00, 2'b00);
    @(negedge clk); a_out("b2b_c3", 1, 8'hC3, 0, 0, 0);
    step();
    @(negedge clk); a_out("b2b_c4", 1, 8'hD4, 1, 1, 1);
    step();
    @(negedge clk); a_out("b2b_done", 0, 8'h00, 0, 0, 1);
    chk("b2b_pend", a_pending_out, 2'b00);

    // 4. zero-mask bundle
    a_drive(1, 8'h55, 8'h66, 2'b00);
    @(negedge clk); chk("zm_rdy", a_ready_in, 1);
    a_drive(0, 8'h00, 8'h00, 2'b00);
    @(negedge clk); a_out("zm_after", 0, 8'h00, 0, 0, 1);
    chk("zm_pend", a_pending_out, 2'b00);

    // 5. mispredict mid-bundle, with a competing accept
    a_drive(1, 8'hF6, 8'hE5, 2'b11);
    a_drive(0, 8'h00, 8'h00, 2'b00);
    @(negedge clk); a_out("mp_l0", 1, 8'hE5, 0, 0, 0);
    a_drive(1, 8'h88, 8'h77, 2'b11);
    a_mispredict = 1;
    @(negedge clk);
    chk("mp_valid", a_valid_out, 0);
    chk("mp_rdyin", a_ready_in, 0);
    a_drive(0, 8'h00, 8'h00, 2'b00);
    a_mispredict = 0;
    @(negedge clk); a_out("mp_after", 0, 8'h00, 0, 0, 1);
    chk("mp_pend", a_pending_out, 2'b00);
    step();
    @(negedge clk); chk("mp_drop", a_valid_out, 0);

    // reset asserted mid-bundle clears everything asynchronously
    a_ready_out = 0;
    a_drive(1, 8'h22, 8'h11, 2'b11);
    a_drive(0, 8'h00, 8'h00, 2'b00);
    @(negedge clk); a_out("rm_pre", 1, 8'h11, 0, 0, 0);
    chk("rm_pre_pend", a_pending_out, 2'b11);
    #2 reset = 1'b0;
    #1;
    a_out("rm_async", 0, 8'h00, 0, 0, 0);
    chk("rm_async_pend", a_pending_out, 2'b00);
    @(negedge clk) reset = 1'b1;
    #1 chk("rm_rel_rdy", a_ready_in, 1);
    step();
    @(negedge clk); a_out("rm_after", 0, 8'h00, 0, 0, 1);

    // 3. stall with sparse mask on 4 lanes
    step();
    b_valid_in = 1; b_mask_in = 4'b1010; b_ready_out = 0;
    b_data_in[0] = 8'h11; b_data_in[1] = 8'h22; b_data_in[2] = 8'h33; b_data_in[3] = 8'h44;
    step();
    b_valid_in = 0; b_mask_in = '0;
    for (int i = 0; i < 4; i++) b_data_in[i] = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("st_valid", b_valid_out, 1);
      chk("st_data", b_data_out, 8'h22);
      chk("st_lane", b_lane_out, 1);
      chk("st_pend", b_pending_out, 4'b1010);
      chk("st_rdyin", b_ready_in, 0);
      step();
    end
    b_ready_out = 1;
    @(negedge clk);
    chk("sp_l1_data", b_data_out, 8'h22);
    chk("sp_l1_last", b_last_out, 0);
    step();
    @(negedge clk);
    chk("sp_l3_data", b_data_out, 8'h44);
    chk("sp_l3_lane", b_lane_out, 3);
    chk("sp_l3_last", b_last_out, 1);
    chk("sp_l3_rdyin", b_ready_in, 1);
    step();
    @(negedge clk); chk("sp_done", b_valid_out, 0);

    // 6. random traffic through the scoreboard
    sb_en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      step();
      b_valid_in  = 1'($urandom_range(0, 1));
      b_mask_in   = 4'($urandom_range(0, 15));
      b_ready_out = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) b_data_in[i] = 8'($urandom_range(0, 255));
    end
    step();
    b_valid_in = 0; b_ready_out = 1;
    repeat (6) step();
    @(negedge clk); chk("rnd_drained", b_valid_out, 0);

    // continuous ready_out with nonzero masks must never bubble
    for (int c = 0; c < 60; c++) begin
      step();
      b_valid_in  = 1;
      b_mask_in   = 4'($urandom_range(1, 15));
      b_ready_out = 1;
      for (int i = 0; i < 4; i++) b_data_in[i] = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (c > 0) chk("nobubble", b_valid_out, 1);
    end
    step();
    b_valid_in = 0;
    repeat (6) step();
    @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    chk("final_idle", b_valid_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bundle_serializer.md
Name: bundle_serializer

Overview:
- Transmit-side companion to the single-entry pipeline buffer between frontend stages.
- Accepts a LANES-wide bundle with a per-lane valid mask on a valid/ready input. Emits the valid lanes one per cycle, lowest lane first, on a single-entry valid/ready output.
- Used where a multi-wide group (e.g. a 2-wide decode group) must feed a 1-wide consumer (rename port, issue-queue write port).
- Mispredict flushes all in-flight lanes.

Parameters:
- T, logic, payload type of one lane.
- LANES, 2, bundle width; legal range 2..8.
- IDXW, $clog2(LANES), width of the lane index output (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mispredict  input  1  synchronous flush, active-high.
- valid_in  input  1  upstream bundle valid.
- ready_in  output  1  serializer can accept a bundle this cycle.
- data_in  input  T x LANES  bundle payload, lane 0 first.
- mask_in  input  LANES  per-lane valid; bit i qualifies data_in[i].
- valid_out  output  1  data_out valid.
- ready_out  input  1  downstream accepts data_out.
- data_out  output  T  current lane payload.
- lane_out  output  IDXW  source lane index of data_out.
- last_out  output  1  data_out is the final valid lane of its bundle.
- pending_out  output  LANES  remaining-lane mask (debug/perf).

Behaviour:
- State:
  - bundle register buf[LANES];
  - pending mask pend[LANES].
- Derived signals:
  - cur = index of lowest set bit of pend.
  - busy = (pend != 0).
- Outputs (combinational from state):
  - valid_out = busy && !mispredict.
  - data_out = buf[cur]; lane_out = cur.
  - last_out = busy && (pend has exactly one bit set).
  - pending_out = pend.
  - When !busy: data_out = 0, lane_out = 0.
- Output beat fires when valid_out && ready_out. At the next edge, clear bit cur of pend.
- ready_in = !mispredict && reset && (!busy || (valid_out && ready_out && last_out)).
  - The last beat of one bundle and acceptance of the next bundle occur in the same cycle, giving back-to-back bundles with no bubble.
- Accept fires when valid_in && ready_in. At the next edge, buf <= data_in and pend <= mask_in.
- Latency: first lane appears on valid_out the cycle after accept (registered). Throughput is one lane per cycle, so a bundle of k valid lanes occupies k cycles.
- Zero-mask bundle (mask_in = 0): accepted as normal; pend stays 0; no output beat; ready_in stays 1.
- Sparse mask (e.g. 4'b1010 with LANES=4): emits lane 1, then lane 3. last_out is asserted on lane 3.
- Downstream stall (ready_out=0): pend, buf and all outputs hold stable; ready_in=0 while busy.
- Data stability: upstream data_in/mask_in need only be valid in the accept cycle. The output holds its own copy.
- Mispredict (synchronous, highest priority after reset):
  - At the edge: pend <= 0, buf <= 0.
  - During the mispredict cycle: valid_out=0, ready_in=0. No beat or accept is counted even if the handshake signals are high.
- Mispredict and accept in the same cycle: the flush wins; the bundle is dropped.
- Reset (async, active-low):
  - When reset=0, immediately: pend=0, buf=0, valid_out=0, ready_in=0, data_out=0, lane_out=0, last_out=0, pending_out=0.
  - After deassertion: ready_in=1 on the first cycle.
  - Reset asserted mid-bundle discards all remaining lanes.
- No X propagation: unused lanes of buf are captured as given but never driven to data_out.

Test Plan:
1. Reset then idle, LANES=2: hold reset=0 mid-cycle → all outputs 0 asynchronously. Release → ready_in=1, valid_out=0.
2. Full bundle, no stall: data_in={B,A}, mask_in=2'b11, ready_out=1 → cycle+1 data_out=A, lane_out=0, last_out=0. Cycle+2 data_out=B, lane_out=1, last_out=1, ready_in=1. Next bundle {D,C} accepted that cycle → C appears cycle+3.
3. Stall and sparse mask, LANES=4: mask_in=4'b1010 with ready_out=0 for 3 cycles → data_out=lane1 payload held stable, pending_out=4'b1010, ready_in=0. Then ready_out=1 → lane 1, then lane 3 with last_out=1.
4. Zero-mask bundle: mask_in=0 → no valid_out ever asserted; ready_in remains 1 the following cycle.
5. Mispredict mid-bundle: after lane 0 of a 2'b11 bundle is emitted, assert mispredict with valid_in=1 → valid_out=0 and ready_in=0 that cycle. Next cycle pending_out=0, ready_in=1, and the lane 1 payload is never emitted.
6. Random back-to-back traffic with random ready_out and masks → scoreboard: output sequence equals the in-order concatenation of masked lanes; no bubble between bundles when ready_out=1 continuously.
